// File: rtl/dm_dma.sv
// dm_dma: word-granular block-transfer engine that drives the data-memory port.
// It copies a block of words or fills a range with a constant, one word at a time.
//
// state | meaning
// IDLE  | waiting for start; memory port outputs held at zero
// RD    | reading one source word into dataBuf
// WR    | writing one word (dataBuf in copy mode, pat in fill mode)
// FIN   | one-cycle completion: done pulses, err reports a rejected request
module dm_dma #(
    parameter int LEN_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             fill_en,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      fill_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             MemWrite,
    output logic [31:0]      MemAddr,
    output logic [31:0]      MemDataIn,
    input  logic [31:0]      MemDataOut
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t           state;
    logic [31:0]      srcPtr;
    logic [31:0]      dstPtr;
    logic [31:0]      dataBuf;
    logic [31:0]      pat;
    logic [LEN_W-1:0] cnt;
    logic             mode;
    logic             errR;
    logic             misaligned;

    // The source alignment only matters when the request is a copy.
    assign misaligned = (dst_addr[1:0] != 2'b00) || (!fill_en && (src_addr[1:0] != 2'b00));

    // Transfer sequencer: request latching, validation, pointer and count updates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            srcPtr  <= '0;
            dstPtr  <= '0;
            dataBuf <= '0;
            pat     <= '0;
            cnt     <= '0;
            mode    <= 1'b0;
            errR    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        srcPtr <= src_addr;
                        dstPtr <= dst_addr;
                        cnt    <= len;
                        mode   <= fill_en;
                        pat    <= fill_data;
                        if (misaligned) begin
                            errR  <= 1'b1;
                            state <= FIN;
                        end else if (len == '0) begin
                            errR  <= 1'b0;
                            state <= FIN;
                        end else begin
                            errR  <= 1'b0;
                            state <= fill_en ? WR : RD;
                        end
                    end
                end
                RD: begin
                    dataBuf <= MemDataOut;
                    srcPtr  <= srcPtr + 32'd4;
                    state   <= WR;
                end
                WR: begin
                    dstPtr <= dstPtr + 32'd4;
                    cnt    <= cnt - 1'b1;
                    // Strictly ascending read-then-write: overlapping forward copies replicate.
                    if (cnt == {{(LEN_W-1){1'b0}}, 1'b1})
                        state <= FIN;
                    else
                        state <= mode ? WR : RD;
                end
                FIN: begin
                    errR  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory port and status outputs decoded from the registered state and pointers.
    always_comb begin
        MemWrite  = 1'b0;
        MemAddr   = '0;
        MemDataIn = '0;
        case (state)
            RD: MemAddr = srcPtr;
            WR: begin
                MemAddr   = dstPtr;
                MemWrite  = 1'b1;
                MemDataIn = mode ? pat : dataBuf;
            end
            default: ;
        endcase
        busy = (state != IDLE);
        done = (state == FIN);
        err  = (state == FIN) && errR;
    end

endmodule

// File: doc/dm_dma.md
# dm_dma

Word-granular block-transfer engine: the initiator side of the data-memory port. It drives the same `MemWrite`/`MemAddr`/`MemDataIn` signals the CPU uses and consumes the combinational `MemDataOut` read data. It supports two operations: copying a block of words from one memory range to another, and filling a range with a constant. It sits beside the CPU datapath. The top level gives the engine ownership of the data-memory port whenever `busy` is 1.

## Interface
Parameters:
- `LEN_W`, default 12: width of the word-count field. 4095 words maximum, which covers the 3072-word data memory.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset (`rst==0` resets on the edge).
- `start`  in  1  request strobe; sampled only in IDLE.
- `fill_en`  in  1  sampled with `start`. 1 = fill, 0 = copy.
- `src_addr`  in  32  byte address of the copy source; ignored in fill mode.
- `dst_addr`  in  32  byte address of the destination.
- `len`  in  LEN_W  number of words to transfer.
- `fill_data`  in  32  fill pattern, latched at `start`.
- `busy`  out  1  high from the cycle after `start` is accepted through the FIN cycle inclusive.
- `done`  out  1  one-cycle pulse in FIN.
- `err`  out  1  one-cycle pulse coincident with `done` when the request was rejected.
- `MemWrite`  out  1  memory write enable.
- `MemAddr`  out  32  memory byte address.
- `MemDataIn`  out  32  memory write data.
- `MemDataOut`  in  32  memory read data, combinational from `MemAddr`.

## Operation
- **States:** IDLE, RD, WR, FIN, encoded in 2 bits.
- **Request latching:** in IDLE, `start==1` latches `src_ptr`, `dst_ptr`, `cnt<=len`, `mode<=fill_en` and `pat<=fill_data`.
- **Validation at `start`:**
  - Misaligned request: `dst_addr[1:0]!=0`, or (copy mode and `src_addr[1:0]!=0`). Go to FIN with `err_r=1`. No memory access.
  - `len==0`: go to FIN with `err_r=0`. No memory access.
  - Otherwise: go to RD in copy mode, or WR in fill mode.
- **RD state:**
  - `MemAddr=src_ptr`, `MemWrite=0`.
  - On the edge: `buf<=MemDataOut`, `src_ptr<=src_ptr+4`, go to WR.
- **WR state:**
  - `MemAddr=dst_ptr`, `MemWrite=1`.
  - `MemDataIn=buf` in copy mode, `MemDataIn=pat` in fill mode.
  - On the edge: `dst_ptr<=dst_ptr+4`, `cnt<=cnt-1`.
  - Next state: FIN if `cnt==1`; otherwise RD in copy mode, WR in fill mode.
- **FIN state:** `done=1`, `err=err_r`, `busy=1`. Unconditionally go to IDLE; `err_r` clears.
- **Pointer arithmetic:** pointers are 32-bit and increment by 4, wrapping modulo 2^32. The memory decodes only `[13:2]`, so transfers wrap within the memory.
- **Overlap:** the copy is strictly ascending, one word read then written.
  - With `src<dst<src+4*len`, the source words are replicated forward.
  - This behaviour is defined and must not be "fixed".
- **Start while busy:** `start` in RD, WR or FIN is ignored, with no queueing.
- **Idle outputs:** in IDLE and FIN, `MemWrite=0`, `MemAddr=0`, `MemDataIn=0`.
- **Reset values:** state=IDLE, `busy=0`, `done=0`, `err=0`, `MemWrite=0`, `MemAddr=0`, `MemDataIn=0`, `buf=0`, `cnt=0`.

## Timing
- **Output generation:** `MemWrite`, `MemAddr` and `MemDataIn` are decoded combinationally from the registered state and pointers. `busy`, `done` and `err` are decoded from the state; there is no input-to-output combinational path.
- **Handshake:** `start` is accepted on the edge where it is high in IDLE. `busy` rises in the following cycle.
- **Latency, start edge to `done` cycle:**
  - Copy of N words: RD/WR alternate, 2 cycles per word. `done` is high in cycle 2N+1 after acceptance.
  - Fill of N words: 1 cycle per word. `done` is high in cycle N+1.
  - Rejected request or `len==0`: `done` is high in cycle 1.
- **Back-to-back requests:** IDLE follows FIN, so a new `start` is accepted at the earliest on the edge after FIN.
- **Reset mid-operation:** the state returns to IDLE on that edge and `MemWrite` is 0 in the next cycle. Writes already completed remain in memory, and no `done` is produced.

## Test plan
- **Copy:** memory preloaded at 0x100..0x10C with 0x11,0x22,0x33,0x44; copy `src=0x100`, `dst=0x200`, `len=4` -> 0x200..0x20C read back 0x11..0x44, with exactly 4 `MemWrite` cycles at addresses 0x200,0x204,0x208,0x20C. `done` is high 9 cycles after acceptance, `err=0`, and `busy` is high for 9 cycles.
- **Fill:** `dst=0x40`, `len=3`, `fill_data=0xDEADBEEF` -> 0x40,0x44,0x48 hold 0xDEADBEEF and 0x4C is unchanged. `MemWrite` is high on 3 consecutive cycles and `done` is high 4 cycles after acceptance.
- **Rejection and zero length:**
  - `src=0x102` (copy) -> `done=err=1` one cycle after acceptance, with no `MemWrite`.
  - Fill with `dst=0x101` gives the same result.
  - `len=0` -> `done=1`, `err=0`, with no `MemWrite`.
- **Overlap and start-while-busy:**
  - 0x100..0x108 = 1,2,3; copy `src=0x100`, `dst=0x104`, `len=2` -> 0x104=1, 0x108=1.
  - A second `start` pulsed during that copy is ignored: only 2 writes occur and there is one `done`.
- **Reset mid-copy:** `len=8`; drive `rst=0` on the edge after the 3rd write -> the following cycle shows `busy=0` and `MemWrite=0`. Only the first 3 destination words are updated and no `done` pulse occurs. A fresh `start` afterwards completes normally.
